// File: rtl/infifo_dispatch_pkg.sv
// Shared definitions for the input-FIFO packet dispatcher: FSM encoding,
// thread-select width and default thread count.
package infifo_dispatch_pkg;

    localparam int THREAD_SEL_W    = 3;
    localparam int DEF_NUM_THREADS = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECV   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_NOTIFY = 2'd3
    } disp_state_e;

endpackage

// File: rtl/infifo_dispatch_rr_thread_picker.sv
// Combinational round-robin search: first set bit of `free`, scanning
// upward from last_grant+1 with wrap-around.
module rr_thread_picker
    import infifo_dispatch_pkg::*;
#(
    parameter int NUM_THREADS = DEF_NUM_THREADS
) (
    input  logic [NUM_THREADS-1:0]  free,
    input  logic [THREAD_SEL_W-1:0] last_grant,
    output logic                    found,
    output logic [THREAD_SEL_W-1:0] index
);

    // Scan from the farthest candidate to the nearest so the nearest wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int k = NUM_THREADS; k >= 1; k--) begin
            if (free[(int'(last_grant) + k) % NUM_THREADS]) begin
                found = 1'b1;
                index = THREAD_SEL_W'((int'(last_grant) + k) % NUM_THREADS);
            end
        end
    end

endmodule

// File: rtl/infifo_dispatch.sv
// Packet dispatcher in front of the thread input FIFOs: grants a free thread
// round-robin, streams the packet's words, then pulses enable_cpu_out.
// Optional length limit: define INFIFO_DISPATCH_MAXLEN_EN.
module infifo_dispatch
    import infifo_dispatch_pkg::*;
#(
    parameter int NUM_THREADS = DEF_NUM_THREADS,
    parameter int DATA_WIDTH  = 64,
    parameter int MAX_WORDS   = 256
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_wr,
    input  logic                    in_eop,
    output logic                    in_rdy,
    input  logic [NUM_THREADS-1:0]  thread_release,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [THREAD_SEL_W-1:0] thread_sel,
    output logic                    firstword_out,
    output logic                    fifowrite_out,
    output logic                    enable_cpu_out,
    output logic [NUM_THREADS-1:0]  busy,
    output logic                    len_err
);

    if (NUM_THREADS < 1 || NUM_THREADS > (1 << THREAD_SEL_W) || MAX_WORDS < 1) begin : g_bad_cfg
        $error("infifo_dispatch: unsupported NUM_THREADS/MAX_WORDS");
    end

    disp_state_e              state, state_nxt;
    logic                     grant, accept, wr_ok, found, first_pend;
    logic [THREAD_SEL_W-1:0]  pick, last_grant;
    logic [NUM_THREADS-1:0]   busy_next, set_bit, free_mask;

    assign accept    = in_wr & in_rdy;
    // A release landing in the decision cycle already counts as free.
    assign busy_next = (busy & ~thread_release) | set_bit;
    assign free_mask = ~busy_next;

    rr_thread_picker #(.NUM_THREADS(NUM_THREADS)) u_picker (
        .free       (free_mask),
        .last_grant (last_grant),
        .found      (found),
        .index      (pick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (found) state_nxt = ST_RECV;
            ST_RECV:   if (accept && in_eop) state_nxt = ST_DRAIN;
            ST_DRAIN:  state_nxt = ST_NOTIFY;
            ST_NOTIFY: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_rdy         = 1'b0;
        enable_cpu_out = 1'b0;
        grant          = 1'b0;
        set_bit        = '0;
        case (state)
            ST_IDLE:   grant = found;
            ST_RECV:   in_rdy = 1'b1;
            ST_NOTIFY: begin
                enable_cpu_out      = 1'b1;
                set_bit[thread_sel] = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef INFIFO_DISPATCH_MAXLEN_EN
    localparam int CNT_W = $clog2(MAX_WORDS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

    logic [CNT_W-1:0] word_cnt;
    logic             len_err_q;

    // Words past the limit are still consumed, just not written out.
    assign wr_ok   = (word_cnt != MAX_CNT);
    assign len_err = len_err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_cnt  <= '0;
            len_err_q <= 1'b0;
        end else begin
            len_err_q <= accept & in_eop & ~wr_ok;
            if (grant)               word_cnt <= '0;
            else if (accept && wr_ok) word_cnt <= word_cnt + 1'b1;
        end
    end
`else
    assign wr_ok   = 1'b1;
    assign len_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy          <= '0;
            last_grant    <= THREAD_SEL_W'(NUM_THREADS - 1);
            thread_sel    <= '0;
            first_pend    <= 1'b0;
            out_data      <= '0;
            fifowrite_out <= 1'b0;
            firstword_out <= 1'b0;
        end else begin
            busy          <= busy_next;
            fifowrite_out <= 1'b0;
            firstword_out <= 1'b0;
            if (grant) begin
                thread_sel <= pick;
                last_grant <= pick;
                first_pend <= 1'b1;
            end
            if (accept) begin
                first_pend <= 1'b0;
                if (wr_ok) begin
                    out_data      <= in_data;
                    fifowrite_out <= 1'b1;
                    firstword_out <= first_pend;
                end
            end
        end
    end

endmodule

// File: tb/tb_infifo_dispatch.sv
// Self-checking bench for infifo_dispatch: transaction-level model predicting
// per-cycle outputs, directed scenarios with literal pins, then random traffic.
module tb_infifo_dispatch;

    localparam int NT   = 8;
    localparam int DW   = 64;
    localparam int NCYC = 8192;
`ifdef INFIFO_DISPATCH_MAXLEN_EN
    localparam int MW = 4;
    localparam int LEN_HI = 6;
`else
    localparam int MW = 256;
    localparam int LEN_HI = 5;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_wr = 1'b0, in_eop = 1'b0;
    logic [NT-1:0] thread_release = '0;
    logic          in_rdy, firstword_out, fifowrite_out, enable_cpu_out, len_err;
    logic [DW-1:0] out_data;
    logic [2:0]    thread_sel;
    logic [NT-1:0] busy;

    always #5 clk = ~clk;

    infifo_dispatch #(.NUM_THREADS(NT), .DATA_WIDTH(DW), .MAX_WORDS(MW)) dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_wr(in_wr), .in_eop(in_eop),
        .in_rdy(in_rdy), .thread_release(thread_release), .out_data(out_data),
        .thread_sel(thread_sel), .firstword_out(firstword_out), .fifowrite_out(fifowrite_out),
        .enable_cpu_out(enable_cpu_out), .busy(busy), .len_err(len_err)
    );

    int  n_chk = 0, n_fail = 0, cyc = 0;
    bit  chk_en = 0;

    // Expected outputs indexed by cycle number.
    bit            e_wr[NCYC], e_first[NCYC], e_en[NCYC], e_err[NCYC], e_rdy[NCYC];
    logic [DW-1:0] e_data[NCYC];
    logic [2:0]    e_sel[NCYC];
    logic [NT-1:0] e_busy[NCYC];

    // Model: busy set, last grant, selected thread, receiving flag, packet progress.
    logic [NT-1:0] mb;
    int  mlast, idle_from, en_cyc, wcnt, widx, plen, len_lo, len_hi;
    logic [2:0] msel;
    bit  mrecv, eop_acc;

    int  n_wr_seen, n_en_seen, n_err_seen, both_cyc, en_last_cyc;
    logic [2:0] en_sel;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s cyc=%0d got=timeout want=event", name, cyc);
    endtask

    always @(negedge clk) begin
        if (chk_en && cyc < NCYC) begin
            check("in_rdy",     in_rdy,         e_rdy[cyc]);
            check("fifowrite",  fifowrite_out,  e_wr[cyc]);
            check("firstword",  firstword_out,  e_first[cyc]);
            check("enable_cpu", enable_cpu_out, e_en[cyc]);
            check("len_err",    len_err,        e_err[cyc]);
            check("thread_sel", thread_sel,     e_sel[cyc]);
            check("busy",       busy,           e_busy[cyc]);
            if (e_wr[cyc]) check("out_data", out_data, e_data[cyc]);
            if (fifowrite_out) n_wr_seen++;
            if (len_err) n_err_seen++;
            if (fifowrite_out && firstword_out) both_cyc = cyc;
            if (enable_cpu_out) begin
                n_en_seen++;
                en_last_cyc = cyc;
                en_sel = thread_sel;
            end
        end
    end

    // One clock cycle: drive inputs, advance the model, wait for the edge.
    task automatic step(input logic [NT-1:0] rel, input bit wr);
        logic [NT-1:0] sb, nb;
        bit keep, got;
        int t;
        e_busy[cyc] = mb;
        e_sel[cyc]  = msel;
        e_rdy[cyc]  = mrecv;
        thread_release = rel;
        in_wr   = wr;
        in_eop  = (widx == plen - 1);
        in_data = {$urandom, $urandom};
        sb = '0;
        if (cyc == en_cyc) sb[msel] = 1'b1;
        nb = (mb & ~rel) | sb;
        eop_acc = 0;
        if (mrecv && wr) begin
`ifdef INFIFO_DISPATCH_MAXLEN_EN
            keep = (wcnt < MW);
`else
            keep = 1;
`endif
            e_wr[cyc+1]    = keep;
            e_first[cyc+1] = keep && (widx == 0);
            e_data[cyc+1]  = in_data;
            if (keep) wcnt++;
            if (in_eop) begin
                e_err[cyc+1] = !keep;
                e_en[cyc+2]  = 1;
                en_cyc    = cyc + 2;
                idle_from = cyc + 3;
                mrecv   = 0;
                eop_acc = 1;
                widx    = 0;
                plen    = $urandom_range(len_lo, len_hi);
            end else begin
                widx++;
            end
        end else if (!mrecv && cyc >= idle_from) begin
            got = 0;
            for (int k = 1; k <= NT; k++) begin
                t = (mlast + k) % NT;
                if (!got && !nb[t]) begin
                    got = 1; msel = 3'(t); mlast = t;
                    mrecv = 1; wcnt = 0; widx = 0;
                end
            end
        end
        mb = nb;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        chk_en = 0;
        reset_n = 0;
        in_wr = 0; in_eop = 0; thread_release = '0;
        #1;
        check("rst_in_rdy", in_rdy, 0);
        check("rst_fifowrite", fifowrite_out, 0);
        check("rst_firstword", firstword_out, 0);
        check("rst_enable", enable_cpu_out, 0);
        check("rst_len_err", len_err, 0);
        check("rst_busy", busy, 0);
        check("rst_thread_sel", thread_sel, 0);
        check("rst_out_data", out_data, 0);
        for (int i = 0; i < NCYC; i++) begin
            e_wr[i] = 0; e_first[i] = 0; e_en[i] = 0; e_err[i] = 0;
        end
        mb = '0; mlast = NT - 1; msel = 0; mrecv = 0; en_cyc = -1;
        wcnt = 0; widx = 0; plen = $urandom_range(len_lo, len_hi);
        @(posedge clk); cyc++; #1;
        @(posedge clk); cyc++; #1;
        reset_n = 1;
        idle_from = cyc;
        chk_en = 1;
    endtask

    // Send one packet from its first word, then idle through DRAIN/NOTIFY/IDLE.
    task automatic send_pkt(input int len);
        int n;
        plen = len;
        n = 0;
        eop_acc = 0;
        while (!eop_acc && n < 100) begin
            step('0, 1);
            n++;
        end
        if (!eop_acc) timeout("send_pkt");
        repeat (3) step('0, 0);
    endtask

    initial begin
        len_lo = 2; len_hi = 2;
        do_reset();

        // Single 4-word packet into thread 0.
        n_wr_seen = 0; n_en_seen = 0;
        send_pkt(4);
        check("t1_busy", busy, 8'h01);
        check("t1_en_sel", en_sel, 0);
        check("t1_writes", n_wr_seen, 4);
        check("t1_enables", n_en_seen, 1);

        // Fill threads 1..7 in order.
        for (int i = 1; i < NT; i++) begin
            send_pkt(2);
            check("t2_en_sel", en_sel, i);
        end
        check("t2_busy_full", busy, 8'hFF);
        repeat (5) step('0, 1);
        check("t2_no_rdy", in_rdy, 0);

        // Release 5: granted next cycle.
        step(8'h20, 1);
        check("t3_sel5", thread_sel, 5);
        check("t3_rdy5", in_rdy, 1);
        send_pkt(2);
        check("t3_full_again", busy, 8'hFF);
        // Release 2 and 6 with last grant 5: 6 then 2.
        step(8'h44, 1);
        check("t3_sel6", thread_sel, 6);
        send_pkt(2);
        check("t3_sel2", thread_sel, 2);
        check("t3_rdy2", in_rdy, 1);
        send_pkt(2);

        // Single-word packet on thread 0.
        step(8'h01, 1);
        send_pkt(1);
        check("t4_en_after_write", en_last_cyc, both_cyc + 1);
        check("t4_en_sel", en_sel, 0);

        // Reset in the middle of a packet on thread 3.
        do_reset();
        send_pkt(1); send_pkt(1); send_pkt(1);
        plen = 6;
        repeat (2) step('0, 1);
        check("t5_sel3", thread_sel, 3);
        do_reset();
        send_pkt(2);
        check("t5_after_rst_sel", en_sel, 0);

`ifdef INFIFO_DISPATCH_MAXLEN_EN
        // Over-length packet: truncated writes, one len_err, still enabled.
        n_wr_seen = 0; n_en_seen = 0; n_err_seen = 0;
        send_pkt(6);
        check("t6_writes", n_wr_seen, 4);
        check("t6_len_err", n_err_seen, 1);
        check("t6_enable", n_en_seen, 1);
`endif

        // Random traffic with random releases and word gaps.
        len_lo = 1; len_hi = LEN_HI;
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) do_reset();
            step(($urandom_range(0, 5) == 0) ? NT'($urandom) : '0,
                 $urandom_range(0, 3) != 0);
        end

        chk_en = 0;
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
